irq_grant_controller: RTL and testbench

IRQ_GRANT_CONTROLLER -- requirements
Module: irq_grant_controller

---
 rtl/irq_grant_controller.sv | 136 +++++++++++++
 tb/tb_irq_grant_controller.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_grant_controller.sv
// Interrupt grant controller: captures interrupt rising edges into a pending
// vector, hands the masked pending set to an external round-robin arbiter,
// and offers one grant at a time to the service side until it completes.
module irq_grant_controller #(
    parameter  int BUS_WIDTH = 32,
    localparam int IW        = $clog2(BUS_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BUS_WIDTH-1:0] irq_in,
    input  logic [BUS_WIDTH-1:0] irq_mask,
    output logic [BUS_WIDTH-1:0] pending_bus,
    input  logic [IW-1:0]        bus_priority,
    output logic                 arbitration_ack,
    output logic                 grant_valid,
    output logic [IW-1:0]        grant_id,
    input  logic                 grant_ready,
    input  logic                 done_valid,
    input  logic [IW-1:0]        done_id,
    output logic                 busy,
    output logic                 err_done
);

    typedef enum logic [2:0] {
        IDLE,
        ACK,
        CAPTURE,
        GRANT,
        WAIT_DONE
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [BUS_WIDTH-1:0] irq_prev;
    logic [BUS_WIDTH-1:0] pending;
    logic [BUS_WIDTH-1:0] pending_nxt;
    logic [BUS_WIDTH-1:0] rise;
    logic [BUS_WIDTH-1:0] clear_vec;
    logic                 sel_pending;
    logic                 done_accept;
    logic                 grant_load;

    assign rise        = irq_in & ~irq_prev;
    assign done_accept = (state == WAIT_DONE) && done_valid && (done_id == grant_id);
    // A fresh edge on the line being completed must not be lost, so set wins.
    assign pending_nxt = (pending & ~clear_vec) | rise;
    assign busy        = (state != IDLE);

    // Decode the arbiter winner and the completed line; indices that do not
    // map to a real line select nothing, which reads as "no request".
    always_comb begin
        sel_pending = 1'b0;
        clear_vec   = '0;
        for (int i = 0; i < BUS_WIDTH; i++) begin
            if (bus_priority == IW'(i)) begin
                sel_pending = pending_bus[i];
            end
            if (grant_id == IW'(i)) begin
                clear_vec[i] = done_accept;
            end
        end
    end

    // Grant FSM next-state and Moore outputs.
    always_comb begin
        state_nxt       = state;
        arbitration_ack = 1'b0;
        grant_valid     = 1'b0;
        grant_load      = 1'b0;
        case (state)
            IDLE: begin
                if (|pending_bus) begin
                    state_nxt = ACK;
                end
            end
            ACK: begin
                arbitration_ack = 1'b1;
                state_nxt       = CAPTURE;
            end
            CAPTURE: begin
                // The winner may have been masked or cleared since the ack.
                if (sel_pending) begin
                    grant_load = 1'b1;
                    state_nxt  = GRANT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            GRANT: begin
                grant_valid = 1'b1;
                if (grant_ready) begin
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (done_accept) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Edge capture, pending set, arbiter bus, granted index and error strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_prev    <= '0;
            pending     <= '0;
            pending_bus <= '0;
            grant_id    <= '0;
            err_done    <= 1'b0;
        end else begin
            irq_prev    <= irq_in;
            pending     <= pending_nxt;
            // Built from the next pending value so the arbiter sees new
            // requests and completions without an extra cycle of lag.
            pending_bus <= pending_nxt & irq_mask;
            if (grant_load) begin
                grant_id <= bus_priority;
            end
            err_done    <= done_valid && !done_accept;
        end
    end

endmodule

// File: tb/tb_irq_grant_controller.sv
// Testbench for irq_grant_controller (BUS_WIDTH=8) with a round-robin
// arbiter model driving bus_priority.
module tb_irq_grant_controller;

    localparam int BW = 8;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [BW-1:0] irq_in = '0;
    logic [BW-1:0] irq_mask = 8'hFF;
    logic [BW-1:0] pending_bus;
    logic [IW-1:0] bus_priority;
    logic          arbitration_ack;
    logic          grant_valid;
    logic [IW-1:0] grant_id;
    logic          grant_ready = 1'b0;
    logic          done_valid = 1'b0;
    logic [IW-1:0] done_id = '0;
    logic          busy;
    logic          err_done;

    always #5 clk = ~clk;

    irq_grant_controller #(.BUS_WIDTH(BW)) dut (
        .clk            (clk),
        .rst            (rst),
        .irq_in         (irq_in),
        .irq_mask       (irq_mask),
        .pending_bus    (pending_bus),
        .bus_priority   (bus_priority),
        .arbitration_ack(arbitration_ack),
        .grant_valid    (grant_valid),
        .grant_id       (grant_id),
        .grant_ready    (grant_ready),
        .done_valid     (done_valid),
        .done_id        (done_id),
        .busy           (busy),
        .err_done       (err_done)
    );

    // Round-robin arbiter model: on ack, latch the first request at or after
    // the pointer (wrapping) and move the pointer just past it.
    logic [IW-1:0] arb_win;
    logic [IW-1:0] arb_ptr;
    logic [IW:0]   arb_pick;

    function automatic logic [IW:0] rr_pick(input logic [BW-1:0] req, input logic [IW-1:0] ptr);
        for (int k = 0; k < BW; k++) begin
            int j;
            j = (int'(ptr) + k) % BW;
            if (req[j]) return {1'b1, IW'(j)};
        end
        return '0;
    endfunction

    assign arb_pick     = rr_pick(pending_bus, arb_ptr);
    assign bus_priority = arb_win;

    always @(posedge clk) begin
        if (rst) begin
            arb_win <= '0;
            arb_ptr <= '0;
        end else if (arbitration_ack && arb_pick[IW]) begin
            arb_win <= arb_pick[IW-1:0];
            arb_ptr <= arb_pick[IW-1:0] + 3'd1;
        end
    end

    typedef struct packed {
        logic          rst;
        logic [BW-1:0] irq;
        logic [BW-1:0] mask;
        logic          rdy;
        logic          dv;
        logic [IW-1:0] did;
        logic [BW-1:0] pb;
        logic          ack;
        logic          gv;
        logic [IW-1:0] gid;
        logic          busy;
        logic          err;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   vec_no = 0;

    function automatic vec_t mk(input int r, input int irq, input int mask, input int rdy,
                                input int dv, input int did, input int pb, input int ack,
                                input int gv, input int gid, input int bsy, input int err);
        vec_t v;
        v.rst  = r[0];
        v.irq  = irq[BW-1:0];
        v.mask = mask[BW-1:0];
        v.rdy  = rdy[0];
        v.dv   = dv[0];
        v.did  = did[IW-1:0];
        v.pb   = pb[BW-1:0];
        v.ack  = ack[0];
        v.gv   = gv[0];
        v.gid  = gid[IW-1:0];
        v.busy = bsy[0];
        v.err  = err[0];
        return v;
    endfunction

    // Drive one cycle of inputs away from the active edge and queue its expectation.
    task automatic step(input vec_t v);
        @(negedge clk);
        rst         = v.rst;
        irq_in      = v.irq;
        irq_mask    = v.mask;
        grant_ready = v.rdy;
        done_valid  = v.dv;
        done_id     = v.did;
        exp_q.push_back(v);
    endtask

    task automatic chk(input string name, input int n, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL vec %0d %s: got %h expected %h", n, name, act, exp);
        end
    endtask

    // Scoreboard: each queued expectation is compared just after the edge that consumes it.
    initial begin
        vec_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pending_bus", vec_no, pending_bus, e.pb);
                chk("arbitration_ack", vec_no, {7'b0, arbitration_ack}, {7'b0, e.ack});
                chk("grant_valid", vec_no, {7'b0, grant_valid}, {7'b0, e.gv});
                chk("grant_id", vec_no, {5'b0, grant_id}, {5'b0, e.gid});
                chk("busy", vec_no, {7'b0, busy}, {7'b0, e.busy});
                chk("err_done", vec_no, {7'b0, err_done}, {7'b0, e.err});
                vec_no++;
            end
        end
    end

    initial begin
        // reset, then single line 3: ack, grant 3 cycles after edge, held until ready
        tbl.push_back(mk(1,'h00,'hFF,0,0,0, 'h00,0,0,0,0,0));
        tbl.push_back(mk(1,'h00,'hFF,0,0,0, 'h00,0,0,0,0,0));
        tbl.push_back(mk(0,'h08,'hFF,0,0,0, 'h08,0,0,0,0,0));
        tbl.push_back(mk(0,'h00,'hFF,0,0,0, 'h08,1,0,0,1,0));
        tbl.push_back(mk(0,'h00,'hFF,0,0,0, 'h08,0,0,0,1,0));
        tbl.push_back(mk(0,'h00,'hFF,0,0,0, 'h08,0,1,3,1,0));
        tbl.push_back(mk(0,'h00,'hFF,0,0,0, 'h08,0,1,3,1,0));
        tbl.push_back(mk(0,'h00,'hFF,0,0,0, 'h08,0,1,3,1,0));
        tbl.push_back(mk(0,'h00,'hFF,0,0,0, 'h08,0,1,3,1,0));
        tbl.push_back(mk(0,'h00,'hFF,1,0,0, 'h08,0,0,3,1,0));
        tbl.push_back(mk(0,'h00,'hFF,0,1,3, 'h00,0,0,3,0,0));
        tbl.push_back(mk(0,'h00,'hFF,0,0,0, 'h00,0,0,3,0,0));
        // lines 1 and 5 together: grant 1 then 5, two ack pulses
        tbl.push_back(mk(1,'h00,'hFF,0,0,0, 'h00,0,0,0,0,0));
        tbl.push_back(mk(0,'h22,'hFF,0,0,0, 'h22,0,0,0,0,0));
        tbl.push_back(mk(0,'h00,'hFF,0,0,0, 'h22,1,0,0,1,0));
        tbl.push_back(mk(0,'h00,'hFF,0,0,0, 'h22,0,0,0,1,0));
        tbl.push_back(mk(0,'h00,'hFF,0,0,0, 'h22,0,1,1,1,0));
        tbl.push_back(mk(0,'h00,'hFF,1,0,0, 'h22,0,0,1,1,0));
        tbl.push_back(mk(0,'h00,'hFF,0,1,1, 'h20,0,0,1,0,0));
        tbl.push_back(mk(0,'h00,'hFF,0,0,0, 'h20,1,0,1,1,0));
        tbl.push_back(mk(0,'h00,'hFF,0,0,0, 'h20,0,0,1,1,0));
        tbl.push_back(mk(0,'h00,'hFF,0,0,0, 'h20,0,1,5,1,0));
        tbl.push_back(mk(0,'h00,'hFF,1,0,0, 'h20,0,0,5,1,0));
        tbl.push_back(mk(0,'h00,'hFF,0,1,5, 'h00,0,0,5,0,0));
        tbl.push_back(mk(0,'h00,'hFF,0,0,0, 'h00,0,0,5,0,0));
        // new edge on line 3 coincides with its completion: set wins, regranted
        tbl.push_back(mk(1,'h00,'hFF,0,0,0, 'h00,0,0,0,0,0));
        tbl.push_back(mk(0,'h08,'hFF,0,0,0, 'h08,0,0,0,0,0));
        tbl.push_back(mk(0,'h00,'hFF,0,0,0, 'h08,1,0,0,1,0));
        tbl.push_back(mk(0,'h00,'hFF,0,0,0, 'h08,0,0,0,1,0));
        tbl.push_back(mk(0,'h00,'hFF,0,0,0, 'h08,0,1,3,1,0));
        tbl.push_back(mk(0,'h00,'hFF,1,0,0, 'h08,0,0,3,1,0));
        tbl.push_back(mk(0,'h08,'hFF,0,1,3, 'h08,0,0,3,0,0));
        tbl.push_back(mk(0,'h08,'hFF,0,0,0, 'h08,1,0,3,1,0));
        tbl.push_back(mk(0,'h08,'hFF,0,0,0, 'h08,0,0,3,1,0));
        tbl.push_back(mk(0,'h08,'hFF,0,0,0, 'h08,0,1,3,1,0));
        tbl.push_back(mk(0,'h08,'hFF,1,0,0, 'h08,0,0,3,1,0));
        tbl.push_back(mk(0,'h08,'hFF,0,1,3, 'h00,0,0,3,0,0));
        tbl.push_back(mk(0,'h00,'hFF,0,0,0, 'h00,0,0,3,0,0));
        // masked line 6 stays latched, appears when unmasked
        tbl.push_back(mk(1,'h00,'hFF,0,0,0, 'h00,0,0,0,0,0));
        tbl.push_back(mk(0,'h40,'hBF,0,0,0, 'h00,0,0,0,0,0));
        tbl.push_back(mk(0,'h00,'hBF,0,0,0, 'h00,0,0,0,0,0));
        tbl.push_back(mk(0,'h00,'hBF,0,0,0, 'h00,0,0,0,0,0));
        tbl.push_back(mk(0,'h00,'hFF,0,0,0, 'h40,0,0,0,0,0));
        tbl.push_back(mk(0,'h00,'hFF,0,0,0, 'h40,1,0,0,1,0));
        tbl.push_back(mk(0,'h00,'hFF,0,0,0, 'h40,0,0,0,1,0));
        tbl.push_back(mk(0,'h00,'hFF,0,0,0, 'h40,0,1,6,1,0));
        tbl.push_back(mk(0,'h00,'hFF,1,0,0, 'h40,0,0,6,1,0));
        tbl.push_back(mk(0,'h00,'hFF,0,1,6, 'h00,0,0,6,0,0));
        // wrong completion id in WAIT_DONE, then stray completion in IDLE
        tbl.push_back(mk(1,'h00,'hFF,0,0,0, 'h00,0,0,0,0,0));
        tbl.push_back(mk(0,'h04,'hFF,0,0,0, 'h04,0,0,0,0,0));
        tbl.push_back(mk(0,'h00,'hFF,0,0,0, 'h04,1,0,0,1,0));
        tbl.push_back(mk(0,'h00,'hFF,0,0,0, 'h04,0,0,0,1,0));
        tbl.push_back(mk(0,'h00,'hFF,0,0,0, 'h04,0,1,2,1,0));
        tbl.push_back(mk(0,'h00,'hFF,1,0,0, 'h04,0,0,2,1,0));
        tbl.push_back(mk(0,'h00,'hFF,0,1,4, 'h04,0,0,2,1,1));
        tbl.push_back(mk(0,'h00,'hFF,0,0,0, 'h04,0,0,2,1,0));
        tbl.push_back(mk(0,'h00,'hFF,0,1,2, 'h00,0,0,2,0,0));
        tbl.push_back(mk(0,'h00,'hFF,0,1,2, 'h00,0,0,2,0,1));
        tbl.push_back(mk(0,'h00,'hFF,0,0,0, 'h00,0,0,2,0,0));

        foreach (tbl[i]) step(tbl[i]);

        // line 5 masked between ack and capture: no grant, retried once unmasked;
        // masking after capture keeps the grant and its completion
        step(mk(1,'h00,'hFF,0,0,0, 'h00,0,0,0,0,0));
        step(mk(0,'h20,'hFF,0,0,0, 'h20,0,0,0,0,0));
        step(mk(0,'h00,'hFF,0,0,0, 'h20,1,0,0,1,0));
        step(mk(0,'h00,'hDF,0,0,0, 'h00,0,0,0,1,0));
        step(mk(0,'h00,'hDF,0,0,0, 'h00,0,0,0,0,0));
        step(mk(0,'h00,'hFF,0,0,0, 'h20,0,0,0,0,0));
        step(mk(0,'h00,'hFF,0,0,0, 'h20,1,0,0,1,0));
        step(mk(0,'h00,'hFF,0,0,0, 'h20,0,0,0,1,0));
        step(mk(0,'h00,'hFF,0,0,0, 'h20,0,1,5,1,0));
        step(mk(0,'h00,'hDF,1,0,0, 'h00,0,0,5,1,0));
        step(mk(0,'h00,'hDF,0,1,5, 'h00,0,0,5,0,0));
        step(mk(0,'h00,'hFF,0,0,0, 'h00,0,0,5,0,0));

        // reset during GRANT discards it; line held high through release is a new edge
        step(mk(1,'h00,'hFF,0,0,0, 'h00,0,0,0,0,0));
        step(mk(0,'h08,'hFF,0,0,0, 'h08,0,0,0,0,0));
        step(mk(0,'h00,'hFF,0,0,0, 'h08,1,0,0,1,0));
        step(mk(0,'h00,'hFF,0,0,0, 'h08,0,0,0,1,0));
        step(mk(0,'h00,'hFF,0,0,0, 'h08,0,1,3,1,0));
        step(mk(1,'h10,'hFF,0,1,1, 'h00,0,0,0,0,0));
        step(mk(0,'h10,'hFF,0,0,0, 'h10,0,0,0,0,0));
        step(mk(0,'h10,'hFF,0,0,0, 'h10,1,0,0,1,0));
        step(mk(0,'h10,'hFF,0,0,0, 'h10,0,0,0,1,0));
        step(mk(0,'h10,'hFF,0,0,0, 'h10,0,1,4,1,0));

        for (int w = 0; w < 10 && exp_q.size() != 0; w++) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
